// File: rtl/sign_text_uart_tx_if.sv
// Signal bundle between the sign identification stage and the UART text transmitter.
// sign_valid is a one-cycle strobe qualifying sign_value; there is no ready, the consumer always accepts.
interface sign_text_uart_tx_if;
    logic [3:0] sign_value;
    logic       sign_valid;
    logic       tx;
    logic       tx_busy;
    logic       char_sent;
    logic [7:0] last_char;
    logic [1:0] fsm_state;

    modport master (
        output sign_value, sign_valid,
        input  tx, tx_busy, char_sent, last_char, fsm_state
    );

    modport slave (
        input  sign_value, sign_valid,
        output tx, tx_busy, char_sent, last_char, fsm_state
    );
endinterface

// File: rtl/sign_text_uart_tx.sv
// Debounces the per-frame sign code, maps each newly stable sign to ASCII and
// sends it once per appearance on a UART 8N1 line.
module sign_text_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STABLE_COUNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    sign_text_uart_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift_q, shift_n;
    logic             tx_q, tx_n;
    logic             busy_q, busy_n;
    logic [7:0]       last_char_q, last_char_n;
    logic [3:0]       cand, cand_n;
    logic [3:0]       last_sent, last_sent_n;
    logic [7:0]       stab_cnt, stab_cnt_n;
    logic             pending, pending_n;
    logic             bit_done;
    logic             accept;
    logic             char_sent_c;

    function automatic logic [7:0] map_char(input logic [3:0] code);
        if (code >= 4'd1 && code <= 4'd10)
            return 8'h40 + {4'h0, code};
        else
            return 8'h3F;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            last_char_q <= '0;
            cand        <= '0;
            last_sent   <= '0;
            stab_cnt    <= '0;
            pending     <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            bit_idx     <= bit_idx_n;
            shift_q     <= shift_n;
            tx_q        <= tx_n;
            busy_q      <= busy_n;
            last_char_q <= last_char_n;
            cand        <= cand_n;
            last_sent   <= last_sent_n;
            stab_cnt    <= stab_cnt_n;
            pending     <= pending_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift_q;
        tx_n        = tx_q;
        busy_n      = busy_q;
        last_char_n = last_char_q;
        cand_n      = cand;
        last_sent_n = last_sent;
        stab_cnt_n  = stab_cnt;
        pending_n   = pending;
        accept      = 1'b0;
        char_sent_c = 1'b0;
        bit_done    = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

        case (state)
            IDLE: begin
                if (pending) begin
                    state_n     = START;
                    bit_cnt_n   = '0;
                    shift_n     = map_char(last_sent);
                    last_char_n = map_char(last_sent);
                    tx_n        = 1'b0;
                    busy_n      = 1'b1;
                    pending_n   = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                    tx_n      = shift_q[0];
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = {1'b0, shift_q[7:1]};
                        tx_n      = shift_q[1];
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                char_sent_c = bit_done;
                if (bit_done) begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                    busy_n    = 1'b0;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Debounce runs in every state; an acceptance overrides the launch's clear of pending.
        if (bus.sign_valid) begin
            if (bus.sign_value == cand) begin
                if (stab_cnt != 8'(STABLE_COUNT)) begin
                    stab_cnt_n = stab_cnt + 8'd1;
                    accept     = ((stab_cnt + 8'd1) == 8'(STABLE_COUNT));
                end
            end else begin
                cand_n     = bus.sign_value;
                stab_cnt_n = 8'd1;
                pending_n  = 1'b0;
                accept     = (STABLE_COUNT == 1);
            end
        end

        if (accept) begin
            if (bus.sign_value == 4'd0) begin
                last_sent_n = 4'd0;
            end else if (bus.sign_value != last_sent) begin
                pending_n   = 1'b1;
                last_sent_n = bus.sign_value;
            end
        end
    end

    assign bus.tx        = tx_q;
    assign bus.tx_busy   = busy_q;
    assign bus.char_sent = char_sent_c;
    assign bus.last_char = last_char_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_sign_text_uart_tx.sv
// Randomised and directed stimulus for sign_text_uart_tx, checked by a
// transaction-level model feeding an expected-character queue.
module tb_sign_text_uart_tx;
    localparam int CPB   = 4;
    localparam int SC    = 3;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sign_text_uart_tx_if bus();

    sign_text_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .STABLE_COUNT(SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int         exp_t[$];
    int         cyc = 0;
    int         n_frames = 0;

    // reference model state
    logic [3:0] m_cand;
    logic [3:0] m_last;
    int         m_run;
    logic       m_pend;
    logic [7:0] m_pchar;
    int         m_free_at;

    // monitor state
    logic       in_frame = 1'b0;
    int         off = 0;
    logic [7:0] cur_char;
    int         cur_t;
    logic [7:0] rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_char(input int code);
        string s;
        s = "?ABCDEFGHIJ?????";
        return s[code];
    endfunction

    // Model: a sign is accepted when its run of identical strobes reaches SC;
    // a frame occupies FRAME cycles and the next launch may follow one cycle later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cand    = 4'd0;
            m_last    = 4'd0;
            m_run     = 0;
            m_pend    = 1'b0;
            m_free_at = 0;
            exp_q.delete();
            exp_t.delete();
        end else begin
            cyc++;
            if (m_pend && cyc >= m_free_at) begin
                exp_q.push_back(m_pchar);
                exp_t.push_back(cyc);
                m_free_at = cyc + FRAME + 1;
                m_pend    = 1'b0;
            end
            if (bus.sign_valid) begin
                if (bus.sign_value == m_cand) begin
                    m_run++;
                end else begin
                    m_cand = bus.sign_value;
                    m_run  = 1;
                    m_pend = 1'b0;
                end
                if (m_run == SC) begin
                    if (m_cand == 4'd0) begin
                        m_last = 4'd0;
                    end else if (m_cand != m_last) begin
                        m_pend  = 1'b1;
                        m_pchar = ref_char(int'(m_cand));
                        m_last  = m_cand;
                    end
                end
            end
        end
    end

    // Monitor: decodes every frame on the line cycle by cycle against the expected queue.
    always @(negedge clk) begin
        logic exp_tx;
        if (!rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (bus.tx === 1'b0) begin
                    in_frame = 1'b1;
                    off      = 0;
                    rx       = 8'h00;
                    check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur_char = exp_q.pop_front();
                        cur_t    = exp_t.pop_front();
                    end else begin
                        cur_char = 8'h00;
                        cur_t    = -1;
                    end
                    check("launch_cycle", 32'(cyc), 32'(cur_t));
                    check("last_char", 32'(bus.last_char), 32'(cur_char));
                end else begin
                    check("idle_busy", 32'(bus.tx_busy), 32'd0);
                    check("idle_char_sent", 32'(bus.char_sent), 32'd0);
                end
            end
            if (in_frame) begin
                if (off < CPB)
                    exp_tx = 1'b0;
                else if (off < 9 * CPB)
                    exp_tx = cur_char[(off - CPB) / CPB];
                else
                    exp_tx = 1'b1;
                check("tx_bit", 32'(bus.tx), 32'(exp_tx));
                check("frame_busy", 32'(bus.tx_busy), 32'd1);
                check("char_sent", 32'(bus.char_sent), 32'(off == FRAME - 1));
                if (off >= CPB && off < 9 * CPB && ((off - CPB) % CPB) == CPB / 2)
                    rx[(off - CPB) / CPB] = bus.tx;
                if (off == FRAME - 1) begin
                    check("rx_char", 32'(rx), 32'(cur_char));
                    n_frames++;
                    in_frame = 1'b0;
                end
                off++;
            end
        end
    end

    task automatic strobe(input logic [3:0] v, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sign_value = v;
            bus.sign_valid = 1'b1;
            @(negedge clk);
            bus.sign_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic drain(input string name, input int base, input int exp_delta);
        int i;
        i = 0;
        while ((exp_q.size() > 0 || in_frame || m_pend) && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check({name, "_drain"}, 32'(i < 2000), 32'd1);
        repeat (50) @(negedge clk);
        if (exp_delta >= 0)
            check({name, "_frames"}, 32'(n_frames - base), 32'(exp_delta));
    endtask

    initial begin
        int f0;
        int w;
        bus.sign_value = 4'd0;
        bus.sign_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_char_sent", 32'(bus.char_sent), 32'd0);
        check("rst_last_char", 32'(bus.last_char), 32'd0);
        check("rst_state", 32'(bus.fsm_state), 32'd0);
        rst = 1'b1;

        // single 'A'
        f0 = n_frames;
        strobe(4'd1, 3, 1);
        drain("single_a", f0, 1);

        // held gesture sends once
        strobe(4'd0, 3, 0);
        f0 = n_frames;
        strobe(4'd1, 10, 1);
        drain("held_a", f0, 1);

        // broken run never accepts
        strobe(4'd0, 3, 0);
        f0 = n_frames;
        strobe(4'd1, 2, 0);
        strobe(4'd2, 1, 0);
        strobe(4'd1, 2, 0);
        drain("broken_run", f0, 0);

        // re-arm through zero
        strobe(4'd0, 3, 0);
        f0 = n_frames;
        strobe(4'd1, 3, 0);
        strobe(4'd0, 3, 0);
        strobe(4'd1, 3, 0);
        drain("rearm", f0, 2);

        // unmapped and top code
        f0 = n_frames;
        strobe(4'd12, 3, 0);
        strobe(4'd10, 3, 0);
        drain("mapping", f0, 2);

        // last accepted wins while busy
        strobe(4'd0, 3, 0);
        f0 = n_frames;
        strobe(4'd1, 3, 0);
        strobe(4'd2, 3, 0);
        strobe(4'd3, 3, 0);
        drain("overwrite", f0, 2);

        // reset during data bit 4
        strobe(4'd0, 3, 0);
        strobe(4'd1, 3, 0);
        w = 0;
        while (!(in_frame && off > 20) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("reset_reach_bit4", 32'(w < 200), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_tx", 32'(bus.tx), 32'd1);
        check("async_rst_busy", 32'(bus.tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        f0 = n_frames;
        strobe(4'd1, 3, 0);
        drain("after_reset", f0, 1);

        // random streams
        for (int k = 0; k < 150; k++) begin
            logic [3:0] v;
            case ($urandom_range(0, 5))
                0: v = 4'd0;
                1: v = 4'd1;
                2: v = 4'd2;
                3: v = 4'd3;
                4: v = 4'd12;
                default: v = 4'($urandom_range(0, 15));
            endcase
            strobe(v, $urandom_range(1, 5), $urandom_range(0, 8));
        end
        drain("random", n_frames, -1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
